bcd_seg7_scan: RTL and testbench



---
 rtl/seg7_pkg.sv | 28 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd_seg7_scan.sv | 115 +++++++++++
 tb/tb_bcd_seg7_scan.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, segment codes and digit count for the BCD seven-segment scanner.
// Segment bit order is gfedcba, so bit 0 drives segment a.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_DASH  = 7'h40;
    localparam seg_t SEG_BLANK = 7'h00;

    // A nibble outside 0..9 cannot be shown as a decimal digit.
    function automatic logic digit_is_bad(input bcd_digit_t d);
        return (d > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble to seven-segment decoder (internal active-high polarity).
// Non-decimal nibbles decode to a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  bcd_digit_t digit_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Four-digit multiplexed seven-segment driver with a double-buffered BCD input.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module bcd_seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        bcd_valid,
    output logic        bcd_ready,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        digit_err
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0]            div_cnt_q, div_cnt_d;
    logic [1:0]                  dig_idx_q, dig_idx_d;
    logic [4*NUM_DIGITS-1:0]     disp_q;
    logic [4*NUM_DIGITS-1:0]     pend_q;
    logic                        pend_full_q;
    logic                        digit_err_q;
    logic [NUM_DIGITS-1:0]       an_q, an_d;
    seg_t                        seg_q, seg_d;

    logic                        tc;
    logic                        frame_end;
    logic                        capture;

    seg_t                        dig_seg   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]       dig_blank;
    logic [NUM_DIGITS-1:0]       dig_bad;

    assign tc        = (div_cnt_q == DIV_LAST);
    assign frame_end = tc && (dig_idx_q == 2'd3);
    assign bcd_ready = ~pend_full_q & ~rst;
    assign capture   = bcd_valid & bcd_ready;

    assign div_cnt_d = tc ? '0 : div_cnt_q + 1'b1;
    assign dig_idx_d = tc ? dig_idx_q + 2'd1 : dig_idx_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_to_seg7 u_dec (
                .digit_i (disp_q[4*gi +: 4]),
                .seg_o   (dig_seg[gi])
            );

            // Error flag is computed from the pending value because it is
            // loaded on the same edge that pend moves into the display.
            assign dig_bad[gi] = digit_is_bad(pend_q[4*gi +: 4]);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_units
                assign dig_blank[gi] = 1'b0;
            end else begin : g_upper
                assign dig_blank[gi] = ~|disp_q[4*NUM_DIGITS-1 : 4*gi];
            end
`else
            assign dig_blank[gi] = 1'b0;
`endif
        end
    endgenerate

    always_comb begin
        an_d            = '0;
        an_d[dig_idx_q] = 1'b1;
        seg_d           = dig_seg[dig_idx_q];
        if (dig_blank[dig_idx_q]) begin
            an_d  = '0;
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            dig_idx_q   <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            digit_err_q <= 1'b0;
            an_q        <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_q       <= {7{ACTIVE_LOW}};
        end else begin
            div_cnt_q <= div_cnt_d;
            dig_idx_q <= dig_idx_d;

            // Capture needs pend empty and the swap needs it full, so the
            // two branches can never both want to fire on one edge.
            if (frame_end && pend_full_q) begin
                disp_q      <= pend_q;
                pend_full_q <= 1'b0;
                digit_err_q <= |dig_bad;
            end else if (capture) begin
                pend_q      <= bcd_in;
                pend_full_q <= 1'b1;
            end

            an_q  <= an_d ^ {NUM_DIGITS{ACTIVE_LOW}};
            seg_q <= seg_d ^ {7{ACTIVE_LOW}};
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign digit_err = digit_err_q;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Self-checking bench for bcd_seg7_scan with REFRESH_DIV=4 and active-high pins.
// Accepted values are queued with the frame they must appear in and popped at that frame.
module tb_bcd_seg7_scan;

    localparam int RDIV  = 4;
    localparam int FRAME = 4 * RDIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'h0;
    logic        bcd_valid = 1'b0;
    logic        bcd_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        digit_err;

    always #5 clk = ~clk;

    bcd_seg7_scan #(
        .REFRESH_DIV (RDIV),
        .ACTIVE_LOW  (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .bcd_valid (bcd_valid),
        .bcd_ready (bcd_ready),
        .seg       (seg),
        .an        (an),
        .digit_err (digit_err)
    );

    typedef struct {
        int          frame;
        logic [15:0] val;
    } disp_item_t;

    disp_item_t  sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_n   = 0;
    logic        pend_full_m = 1'b0;
    logic        cap_flag    = 1'b0;
    logic [15:0] disp_exp = 16'h0;
    logic [15:0] disp_old = 16'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic [10:0] exp_out(input logic [15:0] v, input int dig);
        logic [3:0] an_e;
        logic [6:0] seg_e;
        an_e  = 4'(1 << dig);
        seg_e = exp_seg(v[4*dig +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (dig > 0 && (v >> (4 * dig)) == 16'h0) begin
            an_e  = 4'h0;
            seg_e = 7'h00;
        end
`endif
        return {an_e, seg_e};
    endfunction

    function automatic logic exp_err(input logic [15:0] v);
        logic e;
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) e = 1'b1;
        end
        return e;
    endfunction

    // One clock: update the handshake/frame model at the edge, then check outputs.
    task automatic step();
        logic       pf_old;
        disp_item_t item;
        int         dig;
        logic [15:0] v;
        @(posedge clk);
        cap_flag = 1'b0;
        if (rst) begin
            edge_n      = 0;
            pend_full_m = 1'b0;
            sb_q.delete();
            disp_exp    = 16'h0;
            disp_old    = 16'h0;
        end else begin
            edge_n++;
            pf_old = pend_full_m;
            if (edge_n % FRAME == 0) begin
                disp_old = disp_exp;
                if (pf_old) pend_full_m = 1'b0;
            end
            if (bcd_valid && !pf_old) begin
                item.frame  = edge_n / FRAME + 1;
                item.val    = bcd_in;
                sb_q.push_back(item);
                pend_full_m = 1'b1;
                cap_flag    = 1'b1;
            end
            while (sb_q.size() > 0 && sb_q[0].frame <= edge_n / FRAME) begin
                item     = sb_q.pop_front();
                disp_exp = item.val;
            end
        end
        #1;
        if (rst) begin
            check("rst_out", 32'({an, seg}), 32'h0);
            check("rst_err", 32'(digit_err), 32'h0);
            check("rst_rdy", 32'(bcd_ready), 32'h0);
        end else begin
            dig = ((edge_n - 1) / RDIV) % 4;
            v   = (edge_n % FRAME == 0) ? disp_old : disp_exp;
            check($sformatf("out@%0d", edge_n), 32'({an, seg}), 32'(exp_out(v, dig)));
            check($sformatf("err@%0d", edge_n), 32'(digit_err), 32'(exp_err(disp_exp)));
            check($sformatf("rdy@%0d", edge_n), 32'(bcd_ready), 32'(!pend_full_m));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align_to(input int r);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (edge_n % FRAME == r) break;
            step();
        end
    endtask

    // Leaves bcd_valid high so a following send() keeps the source asserted.
    task automatic send(input logic [15:0] val);
        bcd_in    = val;
        bcd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (cap_flag) break;
        end
        if (!cap_flag) check($sformatf("accept_%0h", val), 32'(cap_flag), 32'h1);
        $display("send %04h accepted at edge %0d", val, edge_n);
    endtask

    initial begin
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(5);

        send(16'h1234);
        bcd_valid = 1'b0;
        idle(30);

        send(16'h5678);
        send(16'h9999);
        bcd_valid = 1'b0;
        idle(40);

        align_to(FRAME - 1);
        send(16'h4321);
        bcd_valid = 1'b0;
        idle(40);

        send(16'h00A7);
        bcd_valid = 1'b0;
        idle(36);
        send(16'h0007);
        bcd_valid = 1'b0;
        idle(36);
        send(16'h0000);
        bcd_valid = 1'b0;
        idle(36);

        align_to(5);
        send(16'h2468);
        bcd_valid = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
